// File: rtl/prog_gpio_pkg.sv
// Register map and address width shared by the GPIO block.
// Offsets are byte addresses on the Avalon-MM slave.
package prog_gpio_pkg;

  localparam int ADDR_W = 6;

  localparam logic [ADDR_W-1:0] REG_DATA = 6'h00;
  localparam logic [ADDR_W-1:0] REG_DIR  = 6'h04;
  localparam logic [ADDR_W-1:0] REG_MASK = 6'h08;
  localparam logic [ADDR_W-1:0] REG_POL  = 6'h0C;
  localparam logic [ADDR_W-1:0] REG_EDGE = 6'h10;
  localparam logic [ADDR_W-1:0] REG_STAT = 6'h14;
  localparam logic [ADDR_W-1:0] REG_SET  = 6'h18;
  localparam logic [ADDR_W-1:0] REG_CLR  = 6'h1C;
  localparam logic [ADDR_W-1:0] REG_FILT = 6'h20;

endpackage

// File: rtl/prog_gpio_v2_filter.sv
// Per-pin input conditioning: 2-flop synchroniser then glitch filter.
// Ports: clk, rst_n, filt (required count), pin (async), level (filtered).
module gpio_filter #(
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FILT_W-1:0] filt,
  input  logic              pin,
  output logic              level
);

  logic              s1;
  logic              s2;
  logic [FILT_W-1:0] cnt;

  // level follows s2 only after filt+1 consecutive differing samples;
  // comparing against the live filt lets a new count take effect at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= filt) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + FILT_W'(1);
      end
    end
  end

endmodule

// File: rtl/prog_gpio_v2.sv
// Avalon-MM programmable GPIO with filtered inputs and interrupts.
// Ports: clk, reset_n, avs_* slave, irq, pio_o, pio_i.
module prog_gpio_v2
  import prog_gpio_pkg::*;
#(
  parameter int               WIDTH   = 32,
  parameter int               FILT_W  = 8,
  parameter logic [WIDTH-1:0] OUT_RST = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  output logic [WIDTH-1:0]  pio_o,
  input  logic [WIDTH-1:0]  pio_i
);

  logic [WIDTH-1:0]  out_reg;
  logic [WIDTH-1:0]  dir;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  pol;
  logic [WIDTH-1:0]  edge_sel;
  logic [WIDTH-1:0]  status;
  logic [WIDTH-1:0]  in_filt;
  logic [WIDTH-1:0]  prev;
  logic [FILT_W-1:0] filt;

  logic [WIDTH-1:0]  wd;
  logic [WIDTH-1:0]  w1c;
  logic [WIDTH-1:0]  evt;
  logic [WIDTH-1:0]  edge_evt;
  logic [WIDTH-1:0]  lvl_evt;
  logic [31:0]       rdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_filter #(
      .FILT_W(FILT_W)
    ) u_filt (
      .clk  (clk),
      .rst_n(reset_n),
      .filt (filt),
      .pin  (pio_i[i]),
      .level(in_filt[i])
    );
  end

  assign wd    = avs_writedata[WIDTH-1:0];
  assign pio_o = out_reg & dir;

  assign w1c = (avs_write && avs_address == REG_STAT) ? wd : '0;

  // pol=0: rising / high active; pol=1: falling / low active
  assign edge_evt = (in_filt & ~prev & ~pol)
                  | (~in_filt & prev & pol);
  assign lvl_evt  = in_filt ^ pol;
  assign evt      = (edge_sel & edge_evt)
                  | (~edge_sel & lvl_evt);

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      avs_address == REG_DATA:
        rdata = 32'((out_reg & dir) | (in_filt & ~dir));
      avs_address == REG_DIR:  rdata = 32'(dir);
      avs_address == REG_MASK: rdata = 32'(mask);
      avs_address == REG_POL:  rdata = 32'(pol);
      avs_address == REG_EDGE: rdata = 32'(edge_sel);
      avs_address == REG_STAT: rdata = 32'(status);
      avs_address == REG_FILT: rdata = 32'(filt);
      default:                 rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RST;
      dir      <= '0;
      mask     <= '0;
      pol      <= '0;
      edge_sel <= '0;
      filt     <= '0;
    end else if (avs_write) begin
      unique case (1'b1)
        avs_address == REG_DATA: out_reg  <= wd;
        avs_address == REG_SET:  out_reg  <= out_reg | wd;
        avs_address == REG_CLR:  out_reg  <= out_reg & ~wd;
        avs_address == REG_DIR:  dir      <= wd;
        avs_address == REG_MASK: mask     <= wd;
        avs_address == REG_POL:  pol      <= wd;
        avs_address == REG_EDGE: edge_sel <= wd;
        avs_address == REG_FILT:
          filt <= avs_writedata[FILT_W-1:0];
        default: ;
      endcase
    end
  end

  // a set event in the same cycle as W1C keeps the bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status       <= '0;
      prev         <= '0;
      irq          <= 1'b0;
      avs_readdata <= '0;
    end else begin
      status       <= (status & ~w1c) | evt;
      prev         <= in_filt;
      irq          <= |(status & mask);
      avs_readdata <= avs_read ? rdata : '0;
    end
  end

endmodule

// File: doc/prog_gpio_v2.md
PROG_GPIO_V2 -- requirements
Module: prog_gpio_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 32, range 1..32: number of GPIO pins.
REQ-002 SHALL have parameter FILT_W, default 8: width of the glitch-filter count register.
REQ-003 SHALL have parameter OUT_RST, default 0: reset value of the output data register (WIDTH bits).
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port avs_address  in  6  Avalon-MM byte address, word-aligned.
REQ-007 SHALL have port avs_write  in  1  write strobe, no wait states.
REQ-008 SHALL have port avs_writedata  in  32  write data.
REQ-009 SHALL have port avs_read  in  1  read strobe, fixed read latency 1.
REQ-010 SHALL have port avs_readdata  out  32  read data, registered.
REQ-011 SHALL have port irq  out  1  level interrupt request, registered.
REQ-012 SHALL have port pio_o  out  WIDTH  output pins.
REQ-013 SHALL have port pio_i  in  WIDTH  asynchronous input pins.

Function
REQ-014 SHALL decode registers: 0x00 DATA, 0x04 DIR, 0x08 IRQ_MASK, 0x0C IRQ_POL, 0x10 IRQ_EDGE, 0x14 IRQ_STATUS, 0x18 SET, 0x1C CLR, 0x20 FILT; other addresses read 0 and ignore writes.
REQ-015 SHALL drive pio_o = out_reg & DIR (1 = output); pins with DIR=0 drive 0.
REQ-016 SHALL overwrite out_reg on DATA write; SET write ORs writedata into out_reg; CLR write clears bits set in writedata.
REQ-017 SHALL return on DATA read (out_reg & DIR) | (in_filt & ~DIR), zero-extended above WIDTH.
REQ-018 SHALL pass each pio_i bit through a 2-flop synchroniser, then a glitch filter: in_filt bit updates only after the synchronised bit differs from in_filt for FILT+1 consecutive cycles; the counter restarts on any bounce; FILT=0 gives 1-cycle update.
REQ-019 SHALL set IRQ_STATUS bit i, independent of mask, when: IRQ_EDGE[i]=0 (level) and in_filt[i] equals active level (POL=0 high, POL=1 low); IRQ_EDGE[i]=1 and in_filt[i] shows rising (POL=0) or falling (POL=1) transition.
REQ-020 SHALL clear IRQ_STATUS bits on write of 1 (W1C); a set event in the same cycle wins; a level source still active re-sets the bit next cycle.
REQ-021 SHALL drive irq = |(IRQ_STATUS & IRQ_MASK), registered, one cycle after the status/mask change.
REQ-022 SHALL have worst-case pin-to-irq latency of 2 + (FILT+1) + 2 cycles.
REQ-023 SHALL ignore writes to bits >= WIDTH; those bits read 0.
REQ-024 SHALL not reset in_filt history on FILT change; the new count applies to the next compare.

Reset
REQ-025 SHALL on reset_n low asynchronously set out_reg=OUT_RST, DIR, IRQ_MASK, IRQ_POL, IRQ_EDGE, IRQ_STATUS=0, FILT=0, synchronisers/in_filt/counters=0, avs_readdata=0, irq=0.
REQ-026 SHALL leave no spurious edge event in the first cycle after reset release: edge detectors seed from in_filt.

Structure
REQ-027 SHALL place register offsets and the address width constant in package prog_gpio_pkg.
REQ-028 SHALL instantiate sub-module gpio_filter, one per pin (generate), containing synchroniser, counter and in_filt flop.

Verification
REQ-029 SHALL cover: WIDTH=16, DIR=0x00FF, DATA=0xAAAA -> pio_o=0x00AA; pio_i=0x1200 -> DATA reads 0x12AA; SET 0x0001 then CLR 0x0002 -> pio_o=0x00A9.
REQ-030 SHALL cover: FILT=4, 3-cycle glitch on pio_i[0] -> no in_filt change, STATUS=0; 10-cycle pulse -> STATUS[0]=1 within 9 cycles of pin change.
REQ-031 SHALL cover: EDGE[3]=1, POL[3]=1, MASK=0x8, falling pin 3 -> irq=1 held; W1C 0x8 -> irq=0 after 1 cycle; pin stays low -> irq stays 0.
REQ-032 SHALL cover: level mode POL=0, pin 1 held high, W1C 0x2 -> STATUS[1] reasserts next cycle, irq stays 1.
REQ-033 SHALL cover: MASK=0 with event -> STATUS set, irq=0; MASK written 0x1 -> irq=1 one cycle later.
REQ-034 SHALL cover: reset_n pulsed low mid-debounce and with irq=1 -> all outputs 0 immediately, no irq after release with pins stable.
